// File: rtl/cache_sa.sv
// Set-associative, write-through, no-write-allocate cache in front of a
// word-wide RAM. Round-robin replacement per set and multi-word block fill.
// Ports:
//   clk, reset_n            clock and synchronous active-high reset
//   request/address/write_data/write_en   requester side, sampled when ready=1
//   ready/valid/miss/read_data            requester status and load result
//   prop_*                  RAM request/ready handshake (fill and write-through)
//   hit_count/miss_count    saturating access counters
module cache_sa #(
  parameter int unsigned RAM_ADDRESS_BITS   = 10,
  parameter int unsigned CACHE_ADDRESS_BITS = 5,
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned ASOC_BITS          = 1,
  parameter int unsigned BLOCK_BITS         = 2,
  parameter int unsigned COUNT_WIDTH        = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        request,
  input  logic [RAM_ADDRESS_BITS-1:0] address,
  input  logic [DATA_WIDTH-1:0]       write_data,
  input  logic                        write_en,
  output logic                        ready,
  output logic [DATA_WIDTH-1:0]       read_data,
  output logic                        valid,
  output logic                        miss,
  output logic [RAM_ADDRESS_BITS-1:0] prop_address,
  output logic [DATA_WIDTH-1:0]       prop_write_data,
  output logic                        prop_write_en,
  output logic                        prop_request,
  input  logic                        prop_ready,
  input  logic [DATA_WIDTH-1:0]       prop_read_data,
  output logic [COUNT_WIDTH-1:0]      hit_count,
  output logic [COUNT_WIDTH-1:0]      miss_count
);

  localparam int unsigned WAYS  = 2 ** ASOC_BITS;
  localparam int unsigned IDX_W = CACHE_ADDRESS_BITS - ASOC_BITS - BLOCK_BITS;
  localparam int unsigned SETS  = 2 ** IDX_W;
  localparam int unsigned WPB   = 2 ** BLOCK_BITS;
  localparam int unsigned TAG_W = RAM_ADDRESS_BITS - IDX_W - BLOCK_BITS;

  if (ASOC_BITS + BLOCK_BITS >= CACHE_ADDRESS_BITS) begin : g_bad_geometry
    $error("cache_sa: ASOC_BITS + BLOCK_BITS must be less than CACHE_ADDRESS_BITS");
  end

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WRITE, RESP} state_t;

  state_t state_q, state_d;

  // Cache storage
  logic [WAYS-1:0]       vld_q  [SETS];
  logic [ASOC_BITS-1:0]  vict_q [SETS];
  logic [TAG_W-1:0]      tag_q  [WAYS][SETS];
  logic [DATA_WIDTH-1:0] data_q [WAYS][SETS][WPB];

  // Captured request and fill word counter
  logic [RAM_ADDRESS_BITS-1:0] addr_q;
  logic [DATA_WIDTH-1:0]       wdata_q;
  logic                        we_q;
  logic [BLOCK_BITS-1:0]       cnt_q, cnt_d;

  logic [TAG_W-1:0]      tag_f;
  logic [IDX_W-1:0]      idx_f;
  logic [BLOCK_BITS-1:0] off_f;
  assign {tag_f, idx_f, off_f} = addr_q;

  logic                        hit_c;
  logic [ASOC_BITS-1:0]        hit_way_c;
  logic                        fill_xfer_c, fill_last_c;
  logic                        ready_d, valid_d, miss_d, prop_request_d, prop_write_en_d;
  logic [RAM_ADDRESS_BITS-1:0] prop_address_d;

  // Tag compare across all ways of the indexed set
  always_comb begin
    hit_c     = 1'b0;
    hit_way_c = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (vld_q[idx_f][ASOC_BITS'(w)] && (tag_q[ASOC_BITS'(w)][idx_f] == tag_f)) begin
        hit_c     = 1'b1;
        hit_way_c = ASOC_BITS'(w);
      end
    end
  end

  assign fill_xfer_c = (state_q == FILL) && prop_ready;
  assign fill_last_c = fill_xfer_c && (cnt_q == '1);

  // State register
  always_ff @(posedge clk) begin
    if (reset_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state and next values of the registered outputs
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    ready_d         = 1'b0;
    valid_d         = 1'b0;
    miss_d          = 1'b0;
    prop_request_d  = 1'b0;
    prop_write_en_d = 1'b0;
    prop_address_d  = addr_q;
    case (state_q)
      IDLE:   if (request) state_d = LOOKUP;
      LOOKUP: begin
        cnt_d  = '0;
        miss_d = !hit_c;
        if (we_q)       state_d = WRITE;
        else if (hit_c) state_d = RESP;
        else            state_d = FILL;
      end
      FILL:   if (prop_ready) begin
        cnt_d = cnt_q + BLOCK_BITS'(1);
        if (cnt_q == '1) state_d = RESP;
      end
      WRITE:  if (prop_ready) state_d = RESP;
      RESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d         = (state_d == IDLE);
    valid_d         = (state_d == RESP);
    prop_request_d  = (state_d == FILL) || (state_d == WRITE);
    prop_write_en_d = (state_d == WRITE);
    // Fill walks the block from offset 0; write-through uses the captured address
    if (state_d == FILL) prop_address_d = {tag_f, idx_f, cnt_d};
  end

  // Registered outputs, counters, valid bits and victim pointers
  always_ff @(posedge clk) begin
    if (reset_n) begin
      ready           <= 1'b1;
      valid           <= 1'b0;
      miss            <= 1'b0;
      read_data       <= '0;
      prop_request    <= 1'b0;
      prop_write_en   <= 1'b0;
      prop_address    <= '0;
      prop_write_data <= '0;
      hit_count       <= '0;
      miss_count      <= '0;
      for (int s = 0; s < int'(SETS); s++) begin
        vld_q[s]  <= '0;
        vict_q[s] <= '0;
      end
    end else begin
      ready           <= ready_d;
      valid           <= valid_d;
      miss            <= miss_d;
      prop_request    <= prop_request_d;
      prop_write_en   <= prop_write_en_d;
      prop_address    <= prop_address_d;
      prop_write_data <= wdata_q;
      if (state_q == LOOKUP) begin
        if (hit_c) begin
          if (hit_count != '1) hit_count <= hit_count + COUNT_WIDTH'(1);
          if (!we_q) read_data <= data_q[hit_way_c][idx_f][off_f];
        end else if (miss_count != '1) begin
          miss_count <= miss_count + COUNT_WIDTH'(1);
        end
      end
      if (fill_xfer_c && (cnt_q == off_f)) read_data <= prop_read_data;
      if (fill_last_c) begin
        vld_q[idx_f][vict_q[idx_f]] <= 1'b1;
        vict_q[idx_f]               <= vict_q[idx_f] + ASOC_BITS'(1);
      end
    end
  end

  // Request capture, fill counter and the non-reset tag/data arrays
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && request) begin
      addr_q  <= address;
      wdata_q <= write_data;
      we_q    <= write_en;
    end
    cnt_q <= cnt_d;
    if (!reset_n) begin
      if ((state_q == LOOKUP) && we_q && hit_c) data_q[hit_way_c][idx_f][off_f] <= wdata_q;
      if (fill_xfer_c) data_q[vict_q[idx_f]][idx_f][cnt_q] <= prop_read_data;
      if (fill_last_c) tag_q[vict_q[idx_f]][idx_f] <= tag_f;
    end
  end

endmodule

// File: tb/tb_cache_sa.sv
// Self-checking bench for cache_sa: a RAM responder with programmable
// backpressure, a transfer monitor, and a reference model that tracks each
// set as a FIFO of resident tags plus a flat word-addressed memory image.
module tb_cache_sa;
  localparam int SETS = 4;
  localparam int WAYS = 2;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          request = 1'b0;
  logic [9:0]    address = '0;
  logic [31:0]   write_data = '0;
  logic          write_en = 1'b0;
  logic          ready, valid, miss;
  logic [31:0]   read_data;
  logic [9:0]    prop_address;
  logic [31:0]   prop_write_data;
  logic          prop_write_en, prop_request;
  logic          prop_ready = 1'b0;
  logic [31:0]   prop_read_data = '0;
  logic [CW-1:0] hit_count, miss_count;

  int n_checks = 0;
  int n_fail   = 0;

  cache_sa #(
    .RAM_ADDRESS_BITS(10), .CACHE_ADDRESS_BITS(5), .DATA_WIDTH(32),
    .ASOC_BITS(1), .BLOCK_BITS(2), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .request(request), .address(address),
    .write_data(write_data), .write_en(write_en), .ready(ready),
    .read_data(read_data), .valid(valid), .miss(miss),
    .prop_address(prop_address), .prop_write_data(prop_write_data),
    .prop_write_en(prop_write_en), .prop_request(prop_request),
    .prop_ready(prop_ready), .prop_read_data(prop_read_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- RAM responder and monitor ----------------
  bit [31:0] ram [int];
  int stall_len = 0, stall_cnt = 0;
  int xfer_cnt = 0, req_cycles = 0, wr_cnt = 0, stab_err = 0;
  logic [9:0] xfer_addr [$];
  logic prev_req = 1'b0, prev_rdy = 1'b0, prev_we = 1'b0;
  logic [9:0] prev_addr = '0;
  logic [31:0] prev_wd = '0;

  function automatic logic [31:0] ram_word(input logic [9:0] a);
    if (ram.exists(int'(a))) return ram[int'(a)];
    return 32'(a) * 32'd3;
  endfunction

  always @(negedge clk) begin
    if (prop_request) begin
      if (stall_cnt >= stall_len) begin prop_ready = 1'b1; stall_cnt = 0; end
      else begin prop_ready = 1'b0; stall_cnt++; end
      prop_read_data = ram_word(prop_address);
    end else begin
      prop_ready = 1'b0; stall_cnt = 0; prop_read_data = '0;
    end
  end

  always @(posedge clk) begin
    if (prop_request) req_cycles++;
    if (prop_request && prop_ready) begin
      xfer_cnt++;
      xfer_addr.push_back(prop_address);
      if (prop_write_en) begin ram[int'(prop_address)] = prop_write_data; wr_cnt++; end
    end
    if (prev_req && !prev_rdy && prop_request &&
        (prop_address != prev_addr || prop_write_en != prev_we || prop_write_data != prev_wd))
      stab_err++;
    prev_req = prop_request; prev_rdy = prop_ready; prev_we = prop_write_en;
    prev_addr = prop_address; prev_wd = prop_write_data;
  end

  // ---------------- reference model ----------------
  logic [5:0]  m_tags [SETS][$];
  bit   [31:0] ref_mem [int];
  int exp_hits = 0, exp_misses = 0;

  function automatic logic [31:0] ref_word(input logic [9:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return 32'(a) * 32'd3;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) m_tags[s].delete();
    exp_hits = 0; exp_misses = 0;
  endfunction

  function automatic void model_access(input logic [9:0] a, input logic we, input logic [31:0] wd,
                                       output bit m, output logic [31:0] d, output int nx);
    int s;
    bit hit;
    s = int'(a[3:2]);
    hit = 1'b0;
    for (int i = 0; i < m_tags[s].size(); i++) if (m_tags[s][i] == a[9:4]) hit = 1'b1;
    if (hit) begin if (exp_hits < CMAX) exp_hits++; end
    else if (exp_misses < CMAX) exp_misses++;
    if (we) begin
      ref_mem[int'(a)] = wd;
      nx = 1;
    end else if (!hit) begin
      if (m_tags[s].size() == WAYS) void'(m_tags[s].pop_front());
      m_tags[s].push_back(a[9:4]);
      nx = 4;
    end else begin
      nx = 0;
    end
    m = !hit;
    d = ref_word(a);
  endfunction

  // One complete access; k counts rising edges after the request is driven.
  task automatic access(input logic [9:0] a, input logic we, input logic [31:0] wd, input bit drop,
                        output int miss_k, output int nmiss, output int lat, output int nvalid,
                        output logic [31:0] data, output int nx, output int nreq);
    int k, x0, r0;
    k = 0;
    while (!ready && k < 100) begin @(posedge clk); #1; k++; end
    x0 = xfer_cnt; r0 = req_cycles;
    address = a; write_en = we; write_data = wd; request = 1'b1;
    miss_k = -1; nmiss = 0; lat = -1; nvalid = 0; data = '0;
    for (k = 1; k <= 200 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (drop && k == 3) begin request = 1'b1; address = a ^ 10'h200; write_en = 1'b1; end
      else request = 1'b0;
      if (miss) begin nmiss++; if (miss_k < 0) miss_k = k; end
      if (valid) begin nvalid++; lat = k; data = read_data; end
    end
    @(posedge clk); #1;
    if (miss) nmiss++;
    if (valid) nvalid++;
    nx = xfer_cnt - x0; nreq = req_cycles - r0;
  endtask

  task automatic apply_reset();
    request = 1'b0; reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    request = 1'b0; reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({ready, valid, miss, prop_request, prop_write_en} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 10000", {ready, valid, miss, prop_request, prop_write_en});
    end
    n_checks++;
    if (read_data !== 32'h0 || hit_count !== '0 || miss_count !== '0) begin
      n_fail++; $display("FAIL reset_regs: got rd=%0h h=%0d m=%0d required 0/0/0", read_data, hit_count, miss_count);
    end
    reset_n = 1'b0;
    model_reset();
  endtask

  task automatic test_basic_read();
    int mk, nm, lat, nv, nx, nr, x0;
    logic [31:0] d;
    x0 = xfer_addr.size();
    access(10'h004, 1'b0, '0, 1'b0, mk, nm, lat, nv, d, nx, nr);
    n_checks++;
    if (mk !== 2 || nm !== 1) begin n_fail++; $display("FAIL basic_miss: got cycle %0d count %0d required 2/1", mk, nm); end
    n_checks++;
    if (nx !== 4 || xfer_addr.size() < x0 + 4) begin n_fail++; $display("FAIL basic_fill_count: got %0d required 4", nx); end
    else for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (xfer_addr[x0 + i] !== 10'(10'h004 + i)) begin
        n_fail++; $display("FAIL basic_fill_addr%0d: got %0h required %0h", i, xfer_addr[x0 + i], 10'h004 + i);
      end
    end
    n_checks++;
    if (lat !== 6 || d !== 32'h0000000C || nv !== 1) begin
      n_fail++; $display("FAIL basic_resp: got lat=%0d data=%0h nvalid=%0d required 6/c/1", lat, d, nv);
    end
    access(10'h006, 1'b0, '0, 1'b0, mk, nm, lat, nv, d, nx, nr);
    n_checks++;
    if (lat !== 2 || d !== 32'h00000012 || nr !== 0 || nm !== 0) begin
      n_fail++; $display("FAIL basic_hit: got lat=%0d data=%0h req=%0d miss=%0d required 2/12/0/0", lat, d, nr, nm);
    end
    n_checks++;
    if (hit_count !== CW'(1) || miss_count !== CW'(1)) begin
      n_fail++; $display("FAIL basic_counters: got h=%0d m=%0d required 1/1", hit_count, miss_count);
    end
  endtask

  task automatic test_assoc();
    logic [9:0] addrs [8];
    bit exp_m [8];
    int mk, nm, lat, nv, nx, nr, enx;
    bit em;
    logic [31:0] d, ed;
    addrs = '{10'h004, 10'h044, 10'h004, 10'h044, 10'h084, 10'h044, 10'h004, 10'h044};
    exp_m = '{1, 1, 0, 0, 1, 0, 1, 1};
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      model_access(addrs[i], 1'b0, '0, em, ed, enx);
      access(addrs[i], 1'b0, '0, 1'b0, mk, nm, lat, nv, d, nx, nr);
      n_checks++;
      if ((nm == 1) !== exp_m[i] || nx !== enx || d !== ed) begin
        n_fail++; $display("FAIL assoc_%0d addr %0h: got miss=%0d xfers=%0d data=%0h required %0d/%0d/%0h",
                           i, addrs[i], nm, nx, d, exp_m[i], enx, ed);
      end
    end
    n_checks++;
    if (hit_count !== CW'(3) || miss_count !== CW'(5)) begin
      n_fail++; $display("FAIL assoc_counters: got h=%0d m=%0d required 3/5", hit_count, miss_count);
    end
  endtask

  task automatic test_write_hit();
    int mk, nm, lat, nv, nx, nr, w0, enx;
    bit em;
    logic [31:0] d, ed;
    w0 = wr_cnt;
    model_access(10'h005, 1'b1, 32'hDEADBEEF, em, ed, enx);
    access(10'h005, 1'b1, 32'hDEADBEEF, 1'b0, mk, nm, lat, nv, d, nx, nr);
    n_checks++;
    if (nm !== 0 || nx !== 1 || wr_cnt - w0 !== 1 || xfer_addr[$] !== 10'h005 || lat !== 3 || nv !== 1) begin
      n_fail++; $display("FAIL write_hit: got miss=%0d xfers=%0d writes=%0d addr=%0h lat=%0d required 0/1/1/5/3",
                         nm, nx, wr_cnt - w0, xfer_addr[$], lat);
    end
    model_access(10'h005, 1'b0, '0, em, ed, enx);
    access(10'h005, 1'b0, '0, 1'b0, mk, nm, lat, nv, d, nx, nr);
    n_checks++;
    if (nm !== 0 || d !== 32'hDEADBEEF || nr !== 0 || lat !== 2) begin
      n_fail++; $display("FAIL write_hit_read: got miss=%0d data=%0h req=%0d lat=%0d required 0/deadbeef/0/2", nm, d, nr, lat);
    end
  endtask

  task automatic test_write_miss();
    int mk, nm, lat, nv, nx, nr, w0, enx;
    bit em;
    logic [31:0] d, ed;
    w0 = wr_cnt;
    model_access(10'h100, 1'b1, 32'h12345678, em, ed, enx);
    access(10'h100, 1'b1, 32'h12345678, 1'b0, mk, nm, lat, nv, d, nx, nr);
    n_checks++;
    if (nm !== 1 || mk !== 2 || nx !== 1 || nr !== 1 || wr_cnt - w0 !== 1) begin
      n_fail++; $display("FAIL write_miss: got miss=%0d@%0d xfers=%0d req=%0d writes=%0d required 1@2/1/1/1", nm, mk, nx, nr, wr_cnt - w0);
    end
    model_access(10'h100, 1'b0, '0, em, ed, enx);
    access(10'h100, 1'b0, '0, 1'b0, mk, nm, lat, nv, d, nx, nr);
    n_checks++;
    if (nm !== 1 || nx !== 4 || d !== 32'h12345678) begin
      n_fail++; $display("FAIL write_miss_read: got miss=%0d xfers=%0d data=%0h required 1/4/12345678", nm, nx, d);
    end
  endtask

  task automatic test_backpressure();
    int mk, nm, lat, nv, nx, nr, enx, r0, vseen;
    bit em;
    logic [31:0] d, ed;
    stall_len = 3;
    stab_err = 0;
    model_access(10'h208, 1'b0, '0, em, ed, enx);
    access(10'h208, 1'b0, '0, 1'b1, mk, nm, lat, nv, d, nx, nr);
    stall_len = 0;
    n_checks++;
    if (nr !== 16 || nx !== 4 || lat !== 18 || d !== ed) begin
      n_fail++; $display("FAIL backpressure_fill: got req=%0d xfers=%0d lat=%0d data=%0h required 16/4/18/%0h", nr, nx, lat, d, ed);
    end
    n_checks++;
    if (stab_err !== 0) begin n_fail++; $display("FAIL backpressure_stable: got %0d changes required 0", stab_err); end
    r0 = req_cycles; vseen = 0;
    repeat (6) begin @(posedge clk); #1; if (valid || !ready) vseen++; end
    n_checks++;
    if (req_cycles - r0 !== 0 || vseen !== 0) begin
      n_fail++; $display("FAIL dropped_request: got req=%0d busy=%0d required 0/0", req_cycles - r0, vseen);
    end
    n_checks++;
    if (hit_count !== CW'(exp_hits) || miss_count !== CW'(exp_misses)) begin
      n_fail++; $display("FAIL backpressure_counters: got h=%0d m=%0d required %0d/%0d", hit_count, miss_count, exp_hits, exp_misses);
    end
  endtask

  task automatic test_reset_midfill();
    int k, x0, mk, nm, lat, nv, nx, nr, enx;
    bit em;
    logic [31:0] d, ed;
    x0 = xfer_cnt;
    address = 10'h30C; write_en = 1'b0; request = 1'b1;
    @(posedge clk); #1 request = 1'b0;
    k = 0;
    while (xfer_cnt - x0 < 2 && k < 50) begin @(posedge clk); #1; k++; end
    n_checks++;
    if (xfer_cnt - x0 < 2) begin n_fail++; $display("FAIL midfill_start: got %0d words required 2", xfer_cnt - x0); end
    reset_n = 1'b1;
    @(posedge clk); #1 reset_n = 1'b0;
    model_reset();
    n_checks++;
    if (prop_request !== 1'b0 || ready !== 1'b1 || hit_count !== '0 || miss_count !== '0) begin
      n_fail++; $display("FAIL midfill_reset: got preq=%b ready=%b h=%0d m=%0d required 0/1/0/0", prop_request, ready, hit_count, miss_count);
    end
    model_access(10'h30C, 1'b0, '0, em, ed, enx);
    access(10'h30C, 1'b0, '0, 1'b0, mk, nm, lat, nv, d, nx, nr);
    n_checks++;
    if (nm !== 1 || nx !== 4 || d !== 32'h00000924) begin
      n_fail++; $display("FAIL midfill_refill: got miss=%0d xfers=%0d data=%0h required 1/4/924", nm, nx, d);
    end
  endtask

  task automatic test_random();
    int mk, nm, lat, nv, nx, nr, enx, elat, s;
    bit em;
    logic we;
    logic [9:0] a;
    logic [31:0] d, ed, wd;
    for (int i = 0; i < 60; i++) begin
      a  = 10'(($urandom_range(0, 5) << 4) | $urandom_range(0, 15));
      we = ($urandom_range(0, 3) == 0);
      wd = $urandom;
      s  = int'($urandom_range(0, 2));
      stall_len = s;
      model_access(a, we, wd, em, ed, enx);
      access(a, we, wd, 1'b0, mk, nm, lat, nv, d, nx, nr);
      elat = we ? 3 + s : (em ? 2 + 4 * (s + 1) : 2);
      n_checks++;
      if ((nm == 1) !== em || nx !== enx || lat !== elat || nv !== 1 || (!we && d !== ed)) begin
        n_fail++; $display("FAIL random_%0d addr %0h we %0b: got miss=%0d xfers=%0d lat=%0d nvalid=%0d data=%0h required %0d/%0d/%0d/1/%0h",
                           i, a, we, nm, nx, lat, nv, d, em, enx, elat, ed);
      end
    end
    stall_len = 0;
    n_checks++;
    if (hit_count !== CW'(exp_hits) || miss_count !== CW'(exp_misses)) begin
      n_fail++; $display("FAIL random_counters: got h=%0d m=%0d required %0d/%0d", hit_count, miss_count, exp_hits, exp_misses);
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_assoc();
    test_write_hit();
    test_write_miss();
    test_backpressure();
    test_reset_midfill();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
